id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage pipeline. Sits directly downstream of if_stage and consumes if_pc, if_insn and if_en_.
- Reads two GPR ports, forwards operands from EX and MEM, and detects load-use hazards.
- Resolves branches and returns br_taken/br_addr to if_stage.
- Registers decoded control and operands into the ID/EX pipeline register.

Parameters:
- None. Widths come from the shared headers: word data 32, word address 30, register address 5.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- stall  in  1  hold pipeline register
- flush  in  1  squash pipeline register to bubble
- if_pc  in  30  word address of fetched instruction
- if_insn  in  32  fetched instruction
- if_en_  in  1  fetch valid, active-low
- gpr_rd_addr_0 / gpr_rd_addr_1  out  5  = if_insn[25:21] / if_insn[20:16] (ra/rb), combinational
- gpr_rd_data_0 / gpr_rd_data_1  in  32  regfile read data
- ex_en_, ex_gpr_we_  in  1  EX-stage valid and write-enable, active-low
- ex_dst_addr  in  5  EX destination register
- ex_mem_op  in  2  EX memory op
- ex_fwd_data  in  32  EX ALU result
- mem_en_, mem_gpr_we_  in  1  MEM-stage valid and write-enable, active-low
- mem_dst_addr  in  5  MEM destination register
- mem_fwd_data  in  32  MEM result
- br_taken  out  1  branch taken, combinational
- br_addr  out  30  branch target, combinational
- ld_hazard  out  1  load-use hazard, combinational
- id_pc  out  30  registered
- id_en_  out  1  registered, active-low
- id_alu_op  out  4  registered
- id_alu_in_0 / id_alu_in_1  out  32  registered
- id_mem_op  out  2  registered; 0 NONE, 1 LOAD, 2 STORE
- id_mem_wr_data  out  32  registered
- id_dst_addr  out  5  registered
- id_gpr_we_  out  1  registered, active-low

Behaviour:
- Fields: op = insn[31:26], ra = [25:21], rb = [20:16], rc = [15:11], imm = [15:0].
- Register-register ops, op 0x00/0x02/0x04/0x06/0x08/0x0A/0x0C (AND, OR, XOR, ADD, SUB, SHRL, SHLL):
  - alu_op = op[3:1] + 1; in_0 = ra, in_1 = rb, dst = rc, write enabled.
- Immediate forms, op + 1:
  - in_1 = imm, zero-extended for op < 0x06, sign-extended otherwise; dst = rb.
- 0x10 LDW: alu_op ADD (4), in_1 = sext(imm), mem_op LOAD, dst = rb, write enabled.
- 0x11 STW: alu_op ADD, in_1 = sext(imm), mem_op STORE, mem_wr_data = rb, no write.
- 0x12 BE / 0x13 BNE:
  - Taken when ra == rb (BE) or ra != rb (BNE).
  - br_addr = if_pc + 1 + sext(imm), 30-bit wrap-around; no write.
- 0x14 JR: always taken, br_addr = ra[31:2], no write.
- Any other op: decode as NOP (alu_op 0, mem_op NONE, id_gpr_we_ = 1).
- Operand selection for ra/rb, in priority order:
  - EX match: ex_en_ = 0, ex_gpr_we_ = 0, ex_dst_addr = src → ex_fwd_data.
  - Else MEM match (same conditions) → mem_fwd_data.
  - Else regfile data.
  - Register 0 is not special.
- ld_hazard = 1 when if_en_ = 0, ex_en_ = 0, ex_mem_op = LOAD, and ex_dst_addr equals a source the instruction actually uses (ra always; rb only for register-register ops, STW, BE and BNE).
- br_taken is asserted only if the branch condition holds and if_en_ = 0, ld_hazard = 0, flush = 0.
- Pipeline register update, in priority order:
  - reset: id_en_ = 1, id_gpr_we_ = 1, all other outputs 0.
  - flush: same values as reset.
  - stall: hold all outputs.
  - ld_hazard: bubble (id_en_ = 1, id_gpr_we_ = 1, id_mem_op = NONE). The controller stalls IF; the instruction re-decodes next cycle.
  - Otherwise: capture decoded values, id_en_ = if_en_.
- When if_en_ = 1 the captured entry is a bubble: id_gpr_we_ = 1, id_mem_op = NONE.
- Decode latency: 1 cycle from if_* to id_*.
- Reset asserted mid-operation overrides everything immediately (asynchronous).

Optional Feature:
- Macro: ID_FWD_EN.
- Defined: EX/MEM forwarding as above; ld_hazard covers load-use only.
- Undefined:
  - Operands come from the regfile only.
  - ld_hazard (renamed in meaning to data hazard) is asserted for any valid, write-enabled EX or MEM destination matching a used source, load or not.
  - Bubbles are inserted the same way.

Test Plan:
- Reset: pulse reset → id_en_ = 1, id_gpr_we_ = 1, id_alu_op = 0, id_mem_op = 0.
- ADDSI: if_insn = {6'h07, r1, r2, 16'hFFFF}, gpr0 = 5 → next edge id_alu_in_0 = 5, id_alu_in_1 = 32'hFFFFFFFF, id_alu_op = 4, id_dst_addr = 2, id_gpr_we_ = 0.
- Forwarding:
  - ADDR r3 = r1 + r2 with EX writing r1 = 0x10 and MEM writing r2 = 0x20 → id_alu_in_0 = 0x10, id_alu_in_1 = 0x20.
  - Same with EX also writing r2 = 0x30 → id_alu_in_1 = 0x30.
  - Without ID_FWD_EN → ld_hazard = 1 and bubble.
- Load-use: EX = LDW r4, ID = ORR using r4 → ld_hazard = 1, id_en_ = 1 next edge; remove EX load → normal capture.
- Branch: BE with if_pc = 0x100, imm = 16'hFFFE, ra == rb → br_taken = 1, br_addr = 0xFF; ra != rb → br_taken = 0; if_pc = 30'h3FFFFFFF, imm = 1 → br_addr = 1.
- Stall/flush: stall = 1 holds outputs across 3 edges; flush and stall together → bubble; JR with flush = 1 → br_taken = 0.

Source files
------------

// File: rtl/id_stage_if.sv
// id_stage_if: ID/EX pipeline-register bus carrying decoded control and operands to EX.
// Ports: id_pc, id_en_, id_gpr_we_ (active-low valid/write), id_alu_op, id_alu_in_0/1,
//        id_mem_op, id_mem_wr_data, id_dst_addr. Modport master drives the bus; slave consumes it.
interface id_stage_if;
    logic [29:0] id_pc;
    logic        id_en_;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;

    modport master (
        output id_pc, id_en_, id_alu_op, id_alu_in_0, id_alu_in_1,
               id_mem_op, id_mem_wr_data, id_dst_addr, id_gpr_we_
    );

    modport slave (
        input  id_pc, id_en_, id_alu_op, id_alu_in_0, id_alu_in_1,
               id_mem_op, id_mem_wr_data, id_dst_addr, id_gpr_we_
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode. Reads two GPRs, optionally forwards from EX/MEM, detects hazards,
//   resolves branches (br_taken/br_addr combinational) and registers decoded fields into ID/EX (1 cycle).
// Ports: clk/reset (async active-high), stall holds and flush squashes the ID/EX register; if_* from
//   fetch; gpr_rd_* to/from regfile; ex_*/mem_* downstream state; ID/EX bus via id_stage_if.master.
// Macro ID_FWD_EN: defined -> EX/MEM forwarding, ld_hazard is load-use only; undefined -> regfile
//   operands only, ld_hazard flags any valid writing EX/MEM destination that matches a used source.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] if_pc,
    input  logic [31:0] if_insn,
    input  logic        if_en_,
    output logic [4:0]  gpr_rd_addr_0,
    output logic [4:0]  gpr_rd_addr_1,
    input  logic [31:0] gpr_rd_data_0,
    input  logic [31:0] gpr_rd_data_1,
    input  logic        ex_en_,
    input  logic        ex_gpr_we_,
    input  logic [4:0]  ex_dst_addr,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_fwd_data,
    input  logic        mem_en_,
    input  logic        mem_gpr_we_,
    input  logic [4:0]  mem_dst_addr,
    input  logic [31:0] mem_fwd_data,
    output logic        br_taken,
    output logic [29:0] br_addr,
    output logic        ld_hazard,
    id_stage_if.master  id
);
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [5:0] OP_LDW = 6'h10;
    localparam logic [5:0] OP_STW = 6'h11;
    localparam logic [5:0] OP_BE  = 6'h12;
    localparam logic [5:0] OP_BNE = 6'h13;
    localparam logic [5:0] OP_JR  = 6'h14;

    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [31:0] imm_zext, imm_sext;

    assign op       = if_insn[31:26];
    assign ra       = if_insn[25:21];
    assign rb       = if_insn[20:16];
    assign rc       = if_insn[15:11];
    assign imm_zext = {16'h0000, if_insn[15:0]};
    assign imm_sext = {{16{if_insn[15]}}, if_insn[15:0]};

    assign gpr_rd_addr_0 = ra;
    assign gpr_rd_addr_1 = rb;

    logic [31:0] ra_data, rb_data;
    logic        ex_wr, mem_wr;

    assign ex_wr  = !ex_en_ && !ex_gpr_we_;
    assign mem_wr = !mem_en_ && !mem_gpr_we_;

`ifdef ID_FWD_EN
    // EX holds the younger result, so it wins over MEM.
    assign ra_data = (ex_wr && ex_dst_addr == ra)   ? ex_fwd_data  :
                     (mem_wr && mem_dst_addr == ra) ? mem_fwd_data : gpr_rd_data_0;
    assign rb_data = (ex_wr && ex_dst_addr == rb)   ? ex_fwd_data  :
                     (mem_wr && mem_dst_addr == rb) ? mem_fwd_data : gpr_rd_data_1;
`else
    assign ra_data = gpr_rd_data_0;
    assign rb_data = gpr_rd_data_1;

    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_data, mem_fwd_data, ex_mem_op};
`endif

    // 0x00..0x0D: ALU ops, even = register-register, odd = immediate form.
    logic alu_form;
    assign alu_form = (op[5:4] == 2'b00) && (op[3:1] != 3'b111);

    logic [3:0]  d_alu_op;
    logic [31:0] d_in_1;
    logic [1:0]  d_mem_op;
    logic [4:0]  d_dst;
    logic        d_we_;
    logic        uses_rb;
    logic        br_cond;

    always_comb begin
        d_alu_op = 4'd0;
        d_in_1   = rb_data;
        d_mem_op = MEM_NONE;
        d_dst    = 5'd0;
        d_we_    = 1'b1;
        uses_rb  = 1'b0;
        br_cond  = 1'b0;
        if (alu_form) begin
            d_alu_op = {1'b0, op[3:1]} + 4'd1;
            d_we_    = 1'b0;
            if (!op[0]) begin
                d_dst   = rc;
                uses_rb = 1'b1;
            end else begin
                d_dst  = rb;
                // AND/OR/XOR immediates are logical (zero-extended), arithmetic ones sign-extend.
                d_in_1 = (op < 6'h06) ? imm_zext : imm_sext;
            end
        end else begin
            case (op)
                OP_LDW: begin
                    d_alu_op = 4'd4;
                    d_in_1   = imm_sext;
                    d_mem_op = MEM_LOAD;
                    d_dst    = rb;
                    d_we_    = 1'b0;
                end
                OP_STW: begin
                    d_alu_op = 4'd4;
                    d_in_1   = imm_sext;
                    d_mem_op = MEM_STORE;
                    uses_rb  = 1'b1;
                end
                OP_BE: begin
                    uses_rb = 1'b1;
                    br_cond = (ra_data == rb_data);
                end
                OP_BNE: begin
                    uses_rb = 1'b1;
                    br_cond = (ra_data != rb_data);
                end
                OP_JR: br_cond = 1'b1;
                default: ;
            endcase
        end
    end

    logic ex_hit, mem_hit;
    assign ex_hit  = (ex_dst_addr == ra)  || (uses_rb && ex_dst_addr == rb);
    assign mem_hit = (mem_dst_addr == ra) || (uses_rb && mem_dst_addr == rb);

`ifdef ID_FWD_EN
    // Only a load in EX cannot be forwarded in time; MEM results always can.
    assign ld_hazard = !if_en_ && !ex_en_ && (ex_mem_op == MEM_LOAD) && ex_hit;
    logic unused_hit;
    assign unused_hit = mem_hit;
`else
    assign ld_hazard = !if_en_ && ((ex_wr && ex_hit) || (mem_wr && mem_hit));
`endif

    assign br_addr  = (op == OP_JR) ? ra_data[31:2] : (if_pc + 30'd1 + imm_sext[29:0]);
    assign br_taken = br_cond && !if_en_ && !ld_hazard && !flush;

    // A hazard or an empty fetch slot both turn into a bubble that writes nothing.
    logic bubble;
    assign bubble = if_en_ || ld_hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            id.id_pc          <= 30'd0;
            id.id_en_         <= 1'b1;
            id.id_alu_op      <= 4'd0;
            id.id_alu_in_0    <= 32'd0;
            id.id_alu_in_1    <= 32'd0;
            id.id_mem_op      <= MEM_NONE;
            id.id_mem_wr_data <= 32'd0;
            id.id_dst_addr    <= 5'd0;
            id.id_gpr_we_     <= 1'b1;
        end else if (!stall) begin
            id.id_pc          <= if_pc;
            id.id_en_         <= bubble;
            id.id_alu_op      <= d_alu_op;
            id.id_alu_in_0    <= ra_data;
            id.id_alu_in_1    <= d_in_1;
            id.id_mem_op      <= bubble ? MEM_NONE : d_mem_op;
            id.id_mem_wr_data <= rb_data;
            id.id_dst_addr    <= d_dst;
            id.id_gpr_we_     <= bubble | d_we_;
        end
    end
endmodule
